// File: rtl/stream_demux.sv
// stream_demux: registered 1:CHANNELS stream router with optional broadcast.
// Each output channel owns a one-entry holding register with a valid/ready
// handshake, so consumers may stall independently of one another. A word
// whose select names a channel that does not exist is dropped and flagged
// on err_sel for one cycle.
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          select,
  input  logic                      bcast,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      err_sel
);

  logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q,  out_data_d;
  logic                      err_sel_q,   err_sel_d;

  logic [CHANNELS-1:0] can_take;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                sel_ok;
  logic                accept;

  // Handshake decode: in_ready is built only from select, bcast and the
  // channel state, so there is no path from in_valid back to in_ready.
  always_comb begin
    can_take = ~out_valid_q | out_ready;
    // Widen select before comparing so the check stays meaningful when
    // 2**SEL_W == CHANNELS.
    sel_ok   = (32'(select) < CHANNELS);
    sel_hit  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_ok && (32'(select) == k)) sel_hit[k] = 1'b1;
    end

    if (bcast)       in_ready = &can_take;
    else if (sel_ok) in_ready = |(sel_hit & can_take);
    else             in_ready = 1'b1;

    accept = in_valid & in_ready;

    load = '0;
    if (accept) load = bcast ? {CHANNELS{1'b1}} : sel_hit;

    err_sel_d = accept & ~bcast & ~sel_ok;
  end

  // Next state of each holding register: refill wins, otherwise a word
  // stays until its consumer takes it. Data is kept after a drain.
  always_comb begin
    out_valid_d = '0;
    out_data_d  = out_data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      out_valid_d[k] = load[k] | (out_valid_q[k] & ~out_ready[k]);
      if (load[k]) out_data_d[k*WIDTH +: WIDTH] = in_data;
    end
  end

  // Channel registers; reset clears held words so nothing is delivered
  // after a mid-transfer reset, and a word offered during reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      err_sel_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_sel_q   <= err_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance driven from a vector table
// plus hand sequences for reset, and a 3-channel instance for the
// invalid-select drop.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        reset;

  // 4-channel instance
  logic        in_valid, in_ready, bcast, err_sel;
  logic [7:0]  in_data;
  logic [1:0]  select;
  logic [3:0]  out_valid, out_ready;
  logic [31:0] out_data;

  // 3-channel instance
  logic        in_valid3, in_ready3, bcast3, err_sel3;
  logic [7:0]  in_data3;
  logic [1:0]  select3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_demux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .select(select), .bcast(bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel)
  );

  stream_demux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .select(select3), .bcast(bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .err_sel(err_sel3)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        bc;
    logic [7:0]  d;
    logic [3:0]  rdy;
    logic        ir;   // expected in_ready during the cycle
    logic [3:0]  ov;   // expected out_valid after the edge
    logic [31:0] od;   // expected out_data after the edge
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    // step 0-3: unicast to each channel, all consumers ready
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 8'h12, 4'b1111, 1'b1, 4'b0001, 32'h00000012};
    tbl[1]  = '{1'b1, 2'd1, 1'b0, 8'h98, 4'b1111, 1'b1, 4'b0010, 32'h00009812};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 8'hAA, 4'b1111, 1'b1, 4'b0100, 32'h00AA9812};
    tbl[3]  = '{1'b1, 2'd3, 1'b0, 8'h55, 4'b1111, 1'b1, 4'b1000, 32'h55AA9812};
    // step 4-8: channel 2 stalled, channel 1 still flows
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 8'h11, 4'b1011, 1'b1, 4'b0100, 32'h55119812};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'b1011, 1'b0, 4'b0100, 32'h55119812};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 8'h33, 4'b1011, 1'b1, 4'b0110, 32'h55113312};
    tbl[7]  = '{1'b1, 2'd2, 1'b0, 8'h22, 4'b1111, 1'b1, 4'b0100, 32'h55223312};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h55223312};
    // step 9-11: refill a full channel in the cycle it drains
    tbl[9]  = '{1'b1, 2'd0, 1'b0, 8'h77, 4'b1110, 1'b1, 4'b0001, 32'h55223377};
    tbl[10] = '{1'b1, 2'd0, 1'b0, 8'h44, 4'b1111, 1'b1, 4'b0001, 32'h55223344};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h55223344};
    // step 12-16: broadcast waits for stalled channel 3
    tbl[12] = '{1'b1, 2'd3, 1'b0, 8'h66, 4'b0111, 1'b1, 4'b1000, 32'h66223344};
    tbl[13] = '{1'b1, 2'd0, 1'b1, 8'hA5, 4'b0111, 1'b0, 4'b1000, 32'h66223344};
    tbl[14] = '{1'b1, 2'd0, 1'b1, 8'hA5, 4'b1111, 1'b1, 4'b1111, 32'hA5A5A5A5};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b1111, 32'hA5A5A5A5};
    tbl[16] = '{1'b0, 2'd0, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA5A5A5A5};
    // step 17-18: fill channels 1 and 2 ahead of the reset sequence
    tbl[17] = '{1'b1, 2'd1, 1'b0, 8'hC1, 4'b1001, 1'b1, 4'b0010, 32'hA5A5C1A5};
    tbl[18] = '{1'b1, 2'd2, 1'b0, 8'hC2, 4'b1001, 1'b1, 4'b0110, 32'hA5C2C1A5};

    reset = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; select = 2'd0; bcast = 1'b0; out_ready = 4'b0000;
    in_valid3 = 1'b0; in_data3 = 8'h00; select3 = 2'd0; bcast3 = 1'b0; out_ready3 = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data",  out_data,       32'h0);
    chk("reset_err_sel",   32'(err_sel),   32'h0);
    chk("reset_in_ready",  32'(in_ready),  32'h1);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      in_valid  = tbl[i].iv;
      select    = tbl[i].sel;
      bcast     = tbl[i].bc;
      in_data   = tbl[i].d;
      out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_out_data", i),  out_data,       tbl[i].od);
      chk($sformatf("v%0d_err_sel", i),   32'(err_sel),   32'h0);
    end

    // Reset while channels 1 and 2 are full and a word is offered.
    reset = 1'b1; in_valid = 1'b1; select = 2'd3; bcast = 1'b0;
    in_data = 8'hEE; out_ready = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; select = 2'd1;
    chk("mid_reset_out_valid", 32'(out_valid), 32'h0);
    chk("mid_reset_out_data",  out_data,       32'h0);
    chk("mid_reset_err_sel",   32'(err_sel),   32'h0);
    @(negedge clk);
    chk("mid_reset_in_ready",  32'(in_ready),  32'h1);
    @(posedge clk);
    #1;
    chk("post_reset_no_delivery", 32'(out_valid), 32'h0);
    chk("post_reset_data_zero",   out_data,       32'h0);

    // 3-channel instance: hold a word on channel 1, then drop select=3.
    in_valid3 = 1'b1; select3 = 2'd1; in_data3 = 8'h10; out_ready3 = 3'b000;
    @(posedge clk);
    #1;
    chk("c3_load_out_valid", 32'(out_valid3), 32'h2);
    chk("c3_load_out_data",  32'(out_data3),  32'h001000);
    select3 = 2'd3; in_data3 = 8'hFF;
    @(negedge clk);
    chk("c3_badsel_in_ready", 32'(in_ready3), 32'h1);
    @(posedge clk);
    #1;
    in_valid3 = 1'b0; select3 = 2'd0;
    chk("c3_err_pulse",        32'(err_sel3),   32'h1);
    chk("c3_badsel_out_valid", 32'(out_valid3), 32'h2);
    chk("c3_badsel_out_data",  32'(out_data3),  32'h001000);
    @(posedge clk);
    #1;
    chk("c3_err_one_cycle",    32'(err_sel3),   32'h0);
    chk("c3_hold_out_valid",   32'(out_valid3), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Parametrised, registered successor to the 8-bit 1:2 combinational demux: routes a WIDTH-bit input stream to one of CHANNELS output streams, or broadcasts it to all of them.
- Adds a valid/ready handshake and a one-entry holding register per output channel.
- Sits between a single producer and several consumers (register file banks, peripheral ports) that may stall independently.

Parameters:
WIDTH, 8, data width in bits (>=1)
CHANNELS, 4, number of output channels (2..16)
SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  producer offers a word
in_ready  output  1  block accepts the word this cycle
in_data  input  WIDTH  word to route
select  input  SEL_W  target channel index
bcast  input  1  1 = send to every channel; select ignored
out_valid  output  CHANNELS  bit k: channel k holds a word
out_ready  input  CHANNELS  bit k: consumer k takes the word
out_data  output  CHANNELS*WIDTH  channel k at [k*WIDTH +: WIDTH]
err_sel  output  1  one-cycle pulse: a word was dropped because select >= CHANNELS

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset, sampled on the rising edge of clk).
- Reset outputs:
  - out_valid = 0, out_data = 0, err_sel = 0.
  - in_ready follows its combinational equation, so with out_valid = 0 it evaluates to 1.
- Reset asserted mid-transfer discards every held word. A word presented in the same cycle as reset is not accepted.
- Per-channel state: EMPTY (out_valid[k] = 0) or FULL (out_valid[k] = 1).
- can_take[k] = !out_valid[k] || out_ready[k]. A drain and a refill of the same channel may happen in the same cycle.
- in_ready (combinational):
  - bcast = 1: AND of can_take[k] over all k.
  - bcast = 0, select < CHANNELS: can_take[select].
  - bcast = 0, select >= CHANNELS: 1.
- Accept = in_valid && in_ready. On accept:
  - Unicast, valid select: next edge loads in_data into channel select and sets out_valid[select].
  - Broadcast: all channels are loaded and all out_valid bits set on the same edge.
  - Invalid select: word is discarded, no channel changes, err_sel = 1 for exactly the next cycle.
- Latency: accept in cycle n -> out_valid visible in cycle n+1. Sustained throughput is 1 word/cycle when consumers hold out_ready = 1.
- Drain: out_valid[k] && out_ready[k] with no refill of k clears out_valid[k] on the next edge.
- Output data rules:
  - out_data for channel k is stable while out_valid[k] && !out_ready[k].
  - When EMPTY, out_data keeps the last word held (0 after reset).
- out_ready bits of EMPTY channels are ignored.
- Channels never affect each other: a stalled channel k never blocks unicast traffic to channel j != k. Broadcast waits for all channels.
- No combinational path from in_valid to in_ready. in_ready depends only on select, bcast, out_valid and out_ready.
- No word is duplicated or lost except an invalid-select drop.

Test Plan:
- Reset, then WIDTH=8, CHANNELS=4, out_ready=4'b1111, send select=0..3 with data 8'h12, 8'h98, 8'hAA, 8'h55 on back-to-back cycles.
  -> Each word appears on its channel one cycle after accept. in_ready stays 1. No other out_valid bit rises.
- out_ready[2]=0; send 8'h11 then 8'h22 to channel 2.
  -> Channel 2 holds 8'h11. in_ready=0 while select=2. A send of 8'h33 to channel 1 is still accepted and appears next cycle. Raising out_ready[2] drains 8'h11, then 8'h22 is accepted.
- Channel 0 FULL with out_ready[0]=1 while a new 8'h44 targets channel 0.
  -> Accepted the same cycle. out_valid[0] stays 1. out_data[7:0] = 8'h44 next cycle.
- bcast=1, in_data=8'hA5, out_ready[3]=0 with channel 3 FULL.
  -> in_ready=0, nothing loads. Once out_ready[3]=1: accepted, all four channels show 8'hA5 next cycle.
- CHANNELS=3, select=3, in_data=8'hFF.
  -> in_ready=1, err_sel pulses high exactly one cycle, out_valid unchanged.
- Channels 1 and 2 FULL; assert reset for one cycle while in_valid=1.
  -> Next cycle out_valid=0, out_data=0, err_sel=0, in_ready=1. The offered word is not delivered.
